// File: rtl/adder_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_stim_pkg
// Brief    : Shared FSM state type, LFSR taps and default seed for the
//            adder stimulus/checker.
// Revision : 1.0 - initial release
// ============================================================================
package adder_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_stim_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_stim_if
// Brief    : Operand/result bus between the stimulus checker and the adder.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_stim_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid;
  logic [WIDTH:0]   c;

  modport master (output a, output b, output valid, input c);
  modport slave  (input a, input b, input valid, output c);
endinterface
`default_nettype wire

// File: rtl/adder_stim_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : adder_stim_lfsr
// Brief    : 16-bit Fibonacci LFSR that steps only when advance is high.
// Revision : 1.0 - initial release
// ============================================================================
module adder_stim_lfsr
  import adder_stim_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] q
);

  logic [15:0] q_d;
  logic [15:0] q_q;

  always_comb begin
    q_d = q_q;
    if (advance) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/adder_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_stim_checker
// Brief    : Drives pseudo-random operands to an adder and checks its sum.
//            Optional macro ADDER_STIM_DIRECTED_EN prefixes each run with four
//            directed corner-case operand pairs.
// Revision : 1.0 - initial release
// ============================================================================
module adder_stim_checker
  import adder_stim_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int          LAT   = 1,
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   num_ops,
  adder_stim_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         mismatch,
  output logic [7:0]   pass_cnt,
  output logic [7:0]   err_cnt
);

  localparam logic [3:0] WAIT_CYCLES = 4'(LAT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] op_a, op_b;
  logic             valid_q, valid_d;
  logic [WIDTH:0]   exp_q, exp_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [3:0]       wait_q, wait_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             send_go;
  logic             lfsr_adv;
  logic [15:0]      lfsr_q;
  logic             unused_lfsr_bits;

  adder_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q;

`ifdef ADDER_STIM_DIRECTED_EN
  localparam logic [WIDTH-1:0] OP_MAX = '1;

  logic [2:0] dir_idx_q, dir_idx_d, dir_eff;
  logic       dir_hold_q, dir_hold_d, dir_sel;

  // The index restarts at every accepted start; it is consulted in IDLE too.
  always_comb begin
    dir_eff    = (state_q == ST_IDLE) ? 3'd0 : dir_idx_q;
    dir_sel    = (dir_eff < 3'd4);
    op_a       = dir_sel ? ((dir_eff[0] ^ dir_eff[1]) ? OP_MAX : '0) : lfsr_q[WIDTH-1:0];
    op_b       = dir_sel ? (dir_eff[1] ? OP_MAX : '0) : lfsr_q[2*WIDTH-1:WIDTH];
    dir_idx_d  = dir_idx_q;
    dir_hold_d = dir_hold_q;
    if (send_go) begin
      dir_idx_d  = dir_sel ? dir_eff + 3'd1 : dir_eff;
      dir_hold_d = dir_sel;
    end
    lfsr_adv = (state_q == ST_SEND) && !dir_hold_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_idx_q  <= 3'd0;
      dir_hold_q <= 1'b0;
    end else begin
      dir_idx_q  <= dir_idx_d;
      dir_hold_q <= dir_hold_d;
    end
  end
`else
  always_comb begin
    op_a     = lfsr_q[WIDTH-1:0];
    op_b     = lfsr_q[2*WIDTH-1:WIDTH];
    lfsr_adv = (state_q == ST_SEND);
  end
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    valid_d  = 1'b0;
    exp_d    = exp_q;
    rem_d    = rem_q;
    pass_d   = pass_q;
    err_d    = err_q;
    wait_d   = wait_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mismatch = 1'b0;
    send_go  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d  = num_ops;
          pass_d = 8'd0;
          err_d  = 8'd0;
          if (num_ops == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEND;
            send_go = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (LAT == 1) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_CYCLES;
        end
      end
      ST_WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if (bus.c == exp_q) begin
          pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
        end else begin
          mismatch = 1'b1;
          err_d    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end
        rem_d = rem_q - 8'd1;
        if (rem_q != 8'd1) begin
          state_d = ST_SEND;
          send_go = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Operands are registered on entry to SEND so they hold until the next one.
    if (send_go) begin
      valid_d = 1'b1;
      a_d     = op_a;
      b_d     = op_b;
      exp_d   = {1'b0, op_a} + {1'b0, op_b};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      exp_q   <= '0;
      rem_q   <= 8'd0;
      pass_q  <= 8'd0;
      err_q   <= 8'd0;
      wait_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_q;
  assign err_cnt   = err_q;

endmodule
`default_nettype wire
